// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: pass-control, input-buffer and array-feed signals of the systolic sequencer
interface systolic_seq_ctrl_if #(
    parameter int DATA_BW     = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int ADDR_BW     = 8
);
    logic                           start;
    logic [ADDR_BW-1:0]             num_vec;
    logic                           abort;
    logic                           busy;
    logic                           done;
    logic                           we_rl;
    logic                           buf_rd_en;
    logic [ADDR_BW-1:0]             buf_addr;
    logic [MATRIX_SIZE*DATA_BW-1:0] buf_rd_data;
    logic [MATRIX_SIZE*DATA_BW-1:0] din_out;
    logic                           res_valid;
    logic [ADDR_BW-1:0]             res_idx;

    modport master (
        output start, num_vec, abort, buf_rd_data,
        input  busy, done, we_rl, buf_rd_en, buf_addr, din_out, res_valid, res_idx
    );

    modport slave (
        input  start, num_vec, abort, buf_rd_data,
        output busy, done, we_rl, buf_rd_en, buf_addr, din_out, res_valid, res_idx
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: per-pass weight latch, input streaming with diagonal skew and result tagging
module systolic_seq_ctrl #(
    parameter int DATA_BW       = 8,
    parameter int MATRIX_SIZE   = 8,
    parameter int ADDR_BW       = 8,
    parameter int ARRAY_LATENCY = 15
) (
    input logic               clk,
    input logic               rstn,
    systolic_seq_ctrl_if.slave ctrl
);
    localparam int CNT_BW  = $clog2(ARRAY_LATENCY + 2);
    localparam int TAG_LEN = ARRAY_LATENCY + 2;

    if (ARRAY_LATENCY < MATRIX_SIZE - 1) begin : g_bad_latency
        $error("ARRAY_LATENCY must be >= MATRIX_SIZE-1");
    end

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_BW-1:0]             k_q, k_d;
    logic [ADDR_BW-1:0]             buf_addr_q, buf_addr_d;
    logic [CNT_BW-1:0]              cnt_q, cnt_d;
    logic                           busy_q, done_q, we_rl_q, buf_rd_en_q;
    logic                           rd_v_q;
    logic                           clr;
    logic [TAG_LEN-1:0]             tag_v_q;
    logic [ADDR_BW-1:0]             tag_idx_q [TAG_LEN];
    logic [MATRIX_SIZE*DATA_BW-1:0] din;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (ctrl.start) begin
                         state_d = LOAD_W;
                         k_d     = ctrl.num_vec;
                     end
            LOAD_W:  state_d = (k_q != '0) ? STREAM : DONE;
            STREAM:  if (buf_addr_q == k_q - ADDR_BW'(1)) begin
                         state_d = DRAIN;
                         cnt_d   = CNT_BW'(ARRAY_LATENCY + 1);
                     end
            DRAIN:   if (cnt_q == '0) state_d = DONE;
                     else cnt_d = cnt_q - CNT_BW'(1);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ctrl.abort) state_d = IDLE;
        // the address register doubles as the stream position counter
        buf_addr_d = (state_d == STREAM && state_q == STREAM) ? buf_addr_q + ADDR_BW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_rl_q     <= 1'b0;
            buf_rd_en_q <= 1'b0;
            buf_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            busy_q      <= state_d != IDLE;
            done_q      <= state_d == DONE;
            we_rl_q     <= state_d == LOAD_W;
            buf_rd_en_q <= state_d == STREAM;
            buf_addr_q  <= buf_addr_d;
        end
    end

    assign clr = !rstn || ctrl.abort;

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_v_q  <= 1'b0;
            tag_v_q <= '0;
            for (int i = 0; i < TAG_LEN; i++) tag_idx_q[i] <= '0;
        end else begin
            rd_v_q       <= buf_rd_en_q;
            tag_v_q      <= {tag_v_q[TAG_LEN-2:0], buf_rd_en_q};
            tag_idx_q[0] <= buf_addr_q;
            for (int i = 1; i < TAG_LEN; i++) tag_idx_q[i] <= tag_idx_q[i-1];
        end
    end

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
        logic [DATA_BW-1:0] pipe_q [j+1];
        always_ff @(posedge clk) begin
            if (clr) begin
                pipe_q <= '{default: '0};
            end else begin
                pipe_q[0] <= rd_v_q ? ctrl.buf_rd_data[j*DATA_BW +: DATA_BW] : '0;
                for (int i = 1; i <= j; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign din[j*DATA_BW +: DATA_BW] = pipe_q[j];
    end

    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.we_rl     = we_rl_q;
    assign ctrl.buf_rd_en = buf_rd_en_q;
    assign ctrl.buf_addr  = buf_addr_q;
    assign ctrl.din_out   = din;
    assign ctrl.res_valid = tag_v_q[TAG_LEN-1];
    assign ctrl.res_idx   = tag_idx_q[TAG_LEN-1];
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: cycle-exact check of every output against the pass timing formulas
module tb_systolic_seq_ctrl;
    localparam int DW = 8;
    localparam int MS = 8;
    localparam int AW = 8;
    localparam int L  = 15;
    localparam int VW = DW * MS;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.DATA_BW(DW), .MATRIX_SIZE(MS), .ADDR_BW(AW)) bus ();

    systolic_seq_ctrl #(.DATA_BW(DW), .MATRIX_SIZE(MS), .ADDR_BW(AW), .ARRAY_LATENCY(L)) dut (
        .clk (clk),
        .rstn(rstn),
        .ctrl(bus)
    );

    logic [VW-1:0] mem [256];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // synchronous buffer; unread cycles return garbage so zero-fill is exercised
    always @(posedge clk)
        bus.buf_rd_data <= bus.buf_rd_en ? mem[bus.buf_addr] : {$urandom, $urandom};

    function automatic logic [VW-1:0] exp_ctrl(int c, int k, int kill);
        int done_c = (k == 0) ? 2 : k + L + 4;
        int n = c - 4 - L;
        logic rd, rv;
        if (kill >= 0 && c > kill) return '0;
        rd = c >= 2 && c < 2 + k;
        rv = n >= 0 && n < k;
        return VW'({c >= 1 && c <= done_c, c == done_c, c == 1, rd,
                    rd ? AW'(c - 2) : AW'(0), rv, rv ? AW'(n) : AW'(0)});
    endfunction

    function automatic logic [VW-1:0] exp_din(int c, int k, int kill);
        logic [VW-1:0] d = '0;
        if (kill >= 0 && c > kill) return '0;
        for (int j = 0; j < MS; j++) begin
            int n = c - 4 - j;
            if (n >= 0 && n < k) d[j*DW +: DW] = mem[n][j*DW +: DW];
        end
        return d;
    endfunction

    function automatic logic [VW-1:0] obs_ctrl();
        return VW'({bus.busy, bus.done, bus.we_rl, bus.buf_rd_en, bus.buf_addr,
                    bus.res_valid, bus.res_idx});
    endfunction

    task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
    endtask

    // kill<0: no abort/reset; otherwise abort (or reset) is driven during cycle 'kill'
    task automatic run_pass(int k, int kill, bit use_rst, bit hold);
        int last = (kill >= 0) ? kill + L + 12 : ((k == 0) ? 2 : k + L + 4);
        @(posedge clk); #1;
        check($sformatf("idle_ctrl k=%0d", k), obs_ctrl(), '0);
        check($sformatf("idle_din k=%0d", k), bus.din_out, '0);
        bus.start   = 1'b1;
        bus.num_vec = AW'(k);
        if (kill == 0) begin
            if (use_rst) rstn = 1'b0;
            else bus.abort = 1'b1;
        end
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            rstn        = 1'b1;
            bus.abort   = 1'b0;
            bus.start   = hold;
            bus.num_vec = AW'($urandom);
            if (c == kill) begin
                if (use_rst) rstn = 1'b0;
                else bus.abort = 1'b1;
            end
            check($sformatf("ctrl c=%0d k=%0d", c, k), obs_ctrl(), exp_ctrl(c, k, kill));
            check($sformatf("din c=%0d k=%0d", c, k), bus.din_out, exp_din(c, k, kill));
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.num_vec = '0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", obs_ctrl(), '0);
        check("reset_din", bus.din_out, '0);
        rstn = 1'b1;

        run_pass(3, -1, 1'b0, 1'b0);
        run_pass(0, -1, 1'b0, 1'b0);

        for (int a = 0; a < 256; a++) mem[a] = {MS{a[7:0]}};
        run_pass(255, -1, 1'b0, 1'b0);

        fill_random();
        run_pass(4, -1, 1'b0, 1'b1);
        run_pass(2, -1, 1'b0, 1'b0);
        run_pass(8, 5, 1'b0, 1'b0);
        run_pass(5, 0, 1'b0, 1'b0);
        run_pass(8, 10, 1'b1, 1'b0);
        run_pass(2, -1, 1'b0, 1'b0);

        for (int p = 0; p < 8; p++) begin
            int k = $urandom_range(0, 24);
            int kill = ($urandom_range(0, 2) == 0) ? $urandom_range(0, k + L + 4) : -1;
            fill_random();
            run_pass(k, kill, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        bus.start = 1'b0;
        check("final_idle", obs_ctrl(), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
